if_fetch_unit: RTL

- Instruction-fetch stage of the pipelined MIPS core. Owns the PC, the instruction-memory request handshake and the IF/ID pipeline register.
- Obeys the stall, redirect and kill requests issued by the ID-stage controller (PCWr, IF_IDWr, NPCOp, stopNext).
- Produces the ID_instr, ID_PC and ID_stopThis values that the controller and the ID/EXE register consume.

---
 rtl/mips_pipe_pkg.sv | 37 +++
 rtl/npc_calc.sv | 36 +++
 rtl/if_fetch_unit.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/mips_pipe_pkg.sv
// Shared definitions for the MIPS pipeline: NPC select codes, opcodes,
// reset vector, fetch FSM states and the NOP encoding.
package mips_pipe_pkg;

   localparam logic [31:0] RESET_PC_DEF = 32'h0000_3000;
   localparam logic [31:0] NOP_INSTR    = 32'h0000_0000;

   // NPCOp encodings; 2'b11 is reserved and behaves like NPC_SEQ
   localparam logic [1:0] NPC_SEQ = 2'b00;
   localparam logic [1:0] NPC_J   = 2'b01;
   localparam logic [1:0] NPC_BEQ = 2'b10;

   // Primary opcodes
   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_ORI   = 6'h0D;
   localparam logic [5:0] OP_LUI   = 6'h0F;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   // R-type function codes
   localparam logic [5:0] FUNCT_ADDU = 6'h21;
   localparam logic [5:0] FUNCT_SUBU = 6'h23;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_REQ,
      ST_WAIT,
      ST_GOT
   } fetch_state_e;

   function automatic logic [31:0] sign_ext16(input logic [15:0] imm);
      return {{16{imm[15]}}, imm};
   endfunction

endpackage

// File: rtl/npc_calc.sv
// Next-PC target computation (purely combinational). Reused by the branch unit.
module npc_calc
   import mips_pipe_pkg::*;
(
   input  logic [1:0]  npc_op,
   input  logic [31:0] pc,
   input  logic [31:0] id_pc,
   input  logic [25:0] id_imm26,
   output logic [31:0] npc,
   output logic        redirect
);

   logic [31:0] id_pc_plus4;
   logic [31:0] br_offset;

   assign id_pc_plus4 = id_pc + 32'd4;
   assign br_offset   = sign_ext16(id_imm26[15:0]) << 2;

   // Select the target; anything but jump/branch falls through sequentially
   always_comb begin
      npc      = pc + 32'd4;
      redirect = 1'b0;
      case (npc_op)
         NPC_J: begin
            npc      = {id_pc_plus4[31:28], id_imm26, 2'b00};
            redirect = 1'b1;
         end
         NPC_BEQ: begin
            npc      = id_pc_plus4 + br_offset;
            redirect = 1'b1;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: PC, instruction-memory handshake, one-entry fetch
// buffer and IF/ID register. Optional performance counters are built when
// IF_PERF_CNT_EN is defined.
module if_fetch_unit
   import mips_pipe_pkg::*;
#(
   parameter logic [31:0] RESET_PC     = RESET_PC_DEF,
   parameter int          IM_TIMEOUT_W = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        PCWr,
   input  logic        IF_IDWr,
   input  logic [1:0]  NPCOp,
   input  logic        stopNext,
   output logic        im_req,
   output logic [31:0] im_addr,
   input  logic        im_ack,
   input  logic [31:0] im_rdata,
   output logic [31:0] PC,
   output logic [31:0] ID_instr,
   output logic [31:0] ID_PC,
   output logic        ID_valid,
   output logic        ID_stopThis
`ifdef IF_PERF_CNT_EN
  ,output logic [31:0] perf_fetch_cnt,
   output logic [31:0] perf_kill_cnt,
   output logic [31:0] perf_bubble_cnt,
   output logic        perf_im_timeout
`endif
);

   fetch_state_e state_reg, state_next;
   logic [31:0]  pc_reg, pc_next;
   logic [31:0]  buf_data_reg, buf_data_next;
   logic         buf_valid_reg, buf_valid_next;
   logic [31:0]  id_instr_reg, id_instr_next;
   logic [31:0]  id_pc_reg, id_pc_next;
   logic         id_valid_reg, id_valid_next;
   logic         id_stop_reg, id_stop_next;
   logic         pend_redirect_reg, pend_redirect_next;
   logic [31:0]  pend_target_reg, pend_target_next;

   logic        advance, ack_ok, word_in, discard, word_avail, in_flight;
   logic [31:0] word_data, npc;
   logic [1:0]  npc_op_eff;
   logic        redirect;

   assign advance    = IF_IDWr & PCWr;
   assign ack_ok     = im_ack & im_req;
   assign word_in    = ack_ok & ~pend_redirect_reg;
   // A word fetched down the old path after an unresolved redirect is dropped
   assign discard    = ack_ok & pend_redirect_reg;
   assign word_avail = buf_valid_reg | word_in;
   assign word_data  = buf_valid_reg ? buf_data_reg : im_rdata;
   assign in_flight  = (state_reg == ST_REQ) || (state_reg == ST_WAIT);
   assign npc_op_eff = id_stop_reg ? NPC_SEQ : NPCOp;

   npc_calc u_npc_calc (
      .npc_op   (npc_op_eff),
      .pc       (pc_reg),
      .id_pc    (id_pc_reg),
      .id_imm26 (id_instr_reg[25:0]),
      .npc      (npc),
      .redirect (redirect)
   );

   // Fetch FSM next state and request strobe
   always_comb begin
      state_next = state_reg;
      im_req     = 1'b0;
      case (state_reg)
         ST_IDLE: state_next = ST_REQ;
         ST_REQ: begin
            im_req     = 1'b1;
            state_next = im_ack ? ST_GOT : ST_WAIT;
         end
         ST_WAIT: begin
            im_req = 1'b1;
            if (im_ack) state_next = ST_GOT;
         end
         ST_GOT: begin
            if (!buf_valid_reg || advance) state_next = ST_REQ;
         end
         default: state_next = ST_IDLE;
      endcase
   end

   // PC, fetch buffer, IF/ID and pending-redirect update
   always_comb begin
      pc_next            = pc_reg;
      buf_data_next      = buf_data_reg;
      buf_valid_next     = buf_valid_reg;
      id_instr_next      = id_instr_reg;
      id_pc_next         = id_pc_reg;
      id_valid_next      = id_valid_reg;
      id_stop_next       = id_stop_reg;
      pend_redirect_next = pend_redirect_reg;
      pend_target_next   = pend_target_reg;
      if (advance) begin
         if (word_avail) begin
            id_instr_next  = word_data;
            id_pc_next     = pc_reg;
            id_valid_next  = 1'b1;
            id_stop_next   = redirect & stopNext;
            pc_next        = npc;
            buf_valid_next = 1'b0;
         end else begin
            id_instr_next = NOP_INSTR;
            id_pc_next    = pc_reg;
            id_valid_next = 1'b0;
            id_stop_next  = 1'b0;
            // Fall-through fetch still outstanding: remember where to go
            if (redirect) begin
               if (in_flight) begin
                  pend_redirect_next = 1'b1;
                  pend_target_next   = npc;
               end else begin
                  pc_next = npc;
               end
            end
         end
      end else if (word_in) begin
         buf_valid_next = 1'b1;
         buf_data_next  = im_rdata;
      end
      if (discard) begin
         pend_redirect_next = 1'b0;
         pc_next            = (advance && redirect) ? npc : pend_target_reg;
      end
   end

   // State registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg         <= ST_IDLE;
         pc_reg            <= RESET_PC;
         buf_data_reg      <= '0;
         buf_valid_reg     <= 1'b0;
         id_instr_reg      <= NOP_INSTR;
         id_pc_reg         <= '0;
         id_valid_reg      <= 1'b0;
         id_stop_reg       <= 1'b0;
         pend_redirect_reg <= 1'b0;
         pend_target_reg   <= '0;
      end else begin
         state_reg         <= state_next;
         pc_reg            <= pc_next;
         buf_data_reg      <= buf_data_next;
         buf_valid_reg     <= buf_valid_next;
         id_instr_reg      <= id_instr_next;
         id_pc_reg         <= id_pc_next;
         id_valid_reg      <= id_valid_next;
         id_stop_reg       <= id_stop_next;
         pend_redirect_reg <= pend_redirect_next;
         pend_target_reg   <= pend_target_next;
      end
   end

   assign im_addr     = pc_reg;
   assign PC          = pc_reg;
   assign ID_instr    = id_instr_reg;
   assign ID_PC       = id_pc_reg;
   assign ID_valid    = id_valid_reg;
   assign ID_stopThis = id_stop_reg;

`ifdef IF_PERF_CNT_EN
   logic [2:0]              perf_inc;
   logic [IM_TIMEOUT_W-1:0] wait_cnt_reg;
   logic                    im_timeout_reg;

   // 0: valid loads, 1: killed loads plus dropped words, 2: bubbles
   assign perf_inc[0] = advance & word_avail;
   assign perf_inc[1] = (advance & word_avail & redirect & stopNext) | discard;
   assign perf_inc[2] = advance & ~word_avail;

   genvar gi;
   generate
      for (gi = 0; gi < 3; gi++) begin : g_perf
         logic [31:0] cnt_reg;
         // Saturating event counter
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)
               cnt_reg <= '0;
            else if (perf_inc[gi] && (cnt_reg != '1))
               cnt_reg <= cnt_reg + 32'd1;
         end
      end
   endgenerate

   // Count WAIT cycles per request; flag sticky when the limit is exceeded
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wait_cnt_reg   <= '0;
         im_timeout_reg <= 1'b0;
      end else if (state_reg == ST_WAIT && !im_ack) begin
         if (wait_cnt_reg != '1) wait_cnt_reg <= wait_cnt_reg + 1'b1;
         else                    im_timeout_reg <= 1'b1;
      end else begin
         wait_cnt_reg <= '0;
      end
   end

   assign perf_fetch_cnt  = g_perf[0].cnt_reg;
   assign perf_kill_cnt   = g_perf[1].cnt_reg;
   assign perf_bubble_cnt = g_perf[2].cnt_reg;
   assign perf_im_timeout = im_timeout_reg;
`endif

endmodule
